// File: rtl/input_script_player.sv
// Replays a stored (button mask, hold) script onto the game inputs; live buttons pass through when idle.
// Latency: btn_out is registered, one cycle behind btn_live or the step load; no backpressure, writes are dropped while playing.
module input_script_player #(
   parameter int NUM_BTN = 5,
   parameter int DUR_W   = 16,
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int MERGE   = 0
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic [NUM_BTN-1:0] btn_live,
   input  logic               prog_we,
   input  logic [ADDR_W-1:0]  prog_addr,
   input  logic [NUM_BTN-1:0] prog_mask,
   input  logic [DUR_W-1:0]   prog_dur,
   input  logic [ADDR_W:0]    script_len,
   input  logic               loop_en,
   input  logic               start,
   input  logic               stop,
   output logic [NUM_BTN-1:0] btn_out,
   output logic               busy,
   output logic               done,
   output logic [ADDR_W-1:0]  step_idx
);

   typedef enum logic {S_IDLE, S_PLAY} state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [NUM_BTN-1:0] mask_mem [DEPTH];
   logic [DUR_W-1:0]   dur_mem  [DEPTH];

   state_t             state_q, state_d;
   logic [NUM_BTN-1:0] btn_out_q, btn_out_d;
   logic [NUM_BTN-1:0] cur_mask_q, cur_mask_d;
   logic               done_q, done_d;
   logic [ADDR_W-1:0]  step_idx_q, step_idx_d;
   logic [DUR_W-1:0]   cnt_q, cnt_d;

   logic               wr_en;
   logic [ADDR_W:0]    eff_len;
   logic [ADDR_W:0]    idx_ext;
   logic               last_step;
   logic               past_end;
   logic [ADDR_W-1:0]  nxt_idx;
   logic [NUM_BTN-1:0] ld_mask;
   logic [DUR_W-1:0]   ld_dur;
   logic [DUR_W-1:0]   ld_cnt;
   logic [NUM_BTN-1:0] live_or;

   assign wr_en     = prog_we && (state_q == S_IDLE) && ({1'b0, prog_addr} < DEPTH_C);
   assign eff_len   = (script_len > DEPTH_C) ? DEPTH_C : script_len;
   assign idx_ext   = {1'b0, step_idx_q};
   assign past_end  = (idx_ext >= eff_len);
   assign last_step = ((idx_ext + 1'b1) == eff_len);
   assign live_or   = (MERGE != 0) ? btn_live : '0;

   // Index of the step that would be loaded this cycle; memory is read combinationally there.
   assign nxt_idx = (state_q == S_IDLE || last_step) ? '0 : step_idx_q + 1'b1;
   assign ld_mask = mask_mem[nxt_idx];
   assign ld_dur  = dur_mem[nxt_idx];
   assign ld_cnt  = (ld_dur == '0) ? '0 : ld_dur - 1'b1;

   always_ff @(posedge sys_clk) begin
      if (wr_en) begin
         mask_mem[prog_addr] <= prog_mask;
         dur_mem[prog_addr]  <= prog_dur;
      end
   end

   always_comb begin
      state_d    = state_q;
      btn_out_d  = btn_out_q;
      cur_mask_d = cur_mask_q;
      done_d     = 1'b0;
      step_idx_d = step_idx_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            btn_out_d  = btn_live;
            step_idx_d = '0;
            cnt_d      = '0;
            if (start && !stop && (eff_len != '0)) begin
               state_d    = S_PLAY;
               cur_mask_d = ld_mask;
               btn_out_d  = ld_mask | live_or;
               cnt_d      = ld_cnt;
            end
         end
         S_PLAY: begin
            if (stop) begin
               state_d    = S_IDLE;
               btn_out_d  = btn_live;
               step_idx_d = '0;
               cnt_d      = '0;
            end else if (cnt_q != '0) begin
               cnt_d     = cnt_q - 1'b1;
               btn_out_d = cur_mask_q | live_or;
            end else if (past_end || (last_step && !loop_en)) begin
               // A shortened script_len that leaves step_idx past the end also completes normally.
               state_d    = S_IDLE;
               done_d     = 1'b1;
               btn_out_d  = btn_live;
               step_idx_d = '0;
               cnt_d      = '0;
            end else begin
               step_idx_d = nxt_idx;
               cur_mask_d = ld_mask;
               btn_out_d  = ld_mask | live_or;
               cnt_d      = ld_cnt;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= S_IDLE;
         btn_out_q  <= '0;
         cur_mask_q <= '0;
         done_q     <= 1'b0;
         step_idx_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         btn_out_q  <= btn_out_d;
         cur_mask_q <= cur_mask_d;
         done_q     <= done_d;
         step_idx_q <= step_idx_d;
         cnt_q      <= cnt_d;
      end
   end

   assign btn_out  = btn_out_q;
   assign busy     = (state_q == S_PLAY);
   assign done     = done_q;
   assign step_idx = step_idx_q;

endmodule

// File: tb/tb_input_script_player.sv
// Bench for input_script_player: override (MERGE=0) and merge (MERGE=1) instances share all inputs.
// Expected per-cycle outputs are built from the programmed script and compared one cycle at a time.
module tb_input_script_player;

   localparam int NB = 5;
   localparam int DW = 16;
   localparam int AW = 4;

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic [NB-1:0] btn_live;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [NB-1:0] prog_mask;
   logic [DW-1:0] prog_dur;
   logic [AW:0]   script_len;
   logic          loop_en;
   logic          start;
   logic          stop;
   logic [NB-1:0] btn_out, btn_out_m;
   logic          busy, busy_m, done, done_m;
   logic [AW-1:0] step_idx, step_idx_m;

   always #5 sys_clk = ~sys_clk;

   input_script_player #(.NUM_BTN(NB), .DUR_W(DW), .DEPTH(16), .ADDR_W(AW), .MERGE(0)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .btn_live(btn_live), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_mask(prog_mask), .prog_dur(prog_dur),
      .script_len(script_len), .loop_en(loop_en), .start(start), .stop(stop),
      .btn_out(btn_out), .busy(busy), .done(done), .step_idx(step_idx));

   input_script_player #(.NUM_BTN(NB), .DUR_W(DW), .DEPTH(16), .ADDR_W(AW), .MERGE(1)) dut_m (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .btn_live(btn_live), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_mask(prog_mask), .prog_dur(prog_dur),
      .script_len(script_len), .loop_en(loop_en), .start(start), .stop(stop),
      .btn_out(btn_out_m), .busy(busy_m), .done(done_m), .step_idx(step_idx_m));

   typedef struct {
      logic [NB-1:0] btn;
      logic          bsy;
      logic          dn;
      logic [AW-1:0] idx;
   } exp_t;

   typedef struct {
      logic [NB-1:0] live;
      logic [NB-1:0] mask;
      logic [NB-1:0] exp_ovr;
      logic [NB-1:0] exp_mrg;
   } vec_t;

   exp_t          sb[$];
   logic [NB-1:0] sc_mask [16];
   logic [DW-1:0] sc_dur  [16];
   int            n_chk  = 0;
   int            n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic prog(input int a, input logic [NB-1:0] m, input logic [DW-1:0] d);
      prog_we   = 1'b1;
      prog_addr = 4'(a);
      prog_mask = m;
      prog_dur  = d;
      tick();
      prog_we   = 1'b0;
      sc_mask[a] = m;
      sc_dur[a]  = d;
   endtask

   task automatic push_exp(input logic [NB-1:0] b, input logic bs, input logic dn, input logic [AW-1:0] ix);
      exp_t e;
      e.btn = b; e.bsy = bs; e.dn = dn; e.idx = ix;
      sb.push_back(e);
   endtask

   // One-shot playback: each step held max(dur,1) cycles, then one done cycle, then idle.
   task automatic push_play(input int len, input logic [NB-1:0] live);
      int h;
      for (int i = 0; i < len; i++) begin
         h = (sc_dur[i] == 0) ? 1 : int'(sc_dur[i]);
         for (int k = 0; k < h; k++) push_exp(sc_mask[i], 1'b1, 1'b0, 4'(i));
      end
      push_exp(live, 1'b0, 1'b1, 4'd0);
      push_exp(live, 1'b0, 1'b0, 4'd0);
   endtask

   task automatic push_loop(input int len, input int cycles);
      int i, k, h;
      i = 0; k = 0;
      for (int c = 0; c < cycles; c++) begin
         h = (sc_dur[i] == 0) ? 1 : int'(sc_dur[i]);
         push_exp(sc_mask[i], 1'b1, 1'b0, 4'(i));
         k++;
         if (k >= h) begin
            k = 0;
            i = (i + 1) % len;
         end
      end
   endtask

   task automatic start_play();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_sb(input string name);
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk({name, "_btn"},  32'(btn_out),  32'(e.btn));
         chk({name, "_busy"}, 32'(busy),     32'(e.bsy));
         chk({name, "_done"}, 32'(done),     32'(e.dn));
         chk({name, "_idx"},  32'(step_idx), 32'(e.idx));
         if (sb.size() > 0) begin
            tick();
            prog_we = 1'b0;
         end
      end
   endtask

   initial begin
      vec_t pass_tab [4];
      vec_t merge_tab [4];
      pass_tab[0]  = '{5'b10101, 5'b00000, 5'b10101, 5'b10101};
      pass_tab[1]  = '{5'b01010, 5'b00000, 5'b01010, 5'b01010};
      pass_tab[2]  = '{5'b11111, 5'b00000, 5'b11111, 5'b11111};
      pass_tab[3]  = '{5'b00000, 5'b00000, 5'b00000, 5'b00000};
      merge_tab[0] = '{5'b01000, 5'b00001, 5'b00001, 5'b01001};
      merge_tab[1] = '{5'b00000, 5'b10000, 5'b10000, 5'b10000};
      merge_tab[2] = '{5'b11111, 5'b00000, 5'b00000, 5'b11111};
      merge_tab[3] = '{5'b00110, 5'b00011, 5'b00011, 5'b00111};

      sys_rst = 1'b1; btn_live = 5'b11111; prog_we = 1'b0; prog_addr = '0;
      prog_mask = '0; prog_dur = '0; script_len = '0; loop_en = 1'b0;
      start = 1'b0; stop = 1'b0;
      repeat (3) tick();
      chk("rst_btn", 32'(btn_out), 0);
      chk("rst_btn_m", 32'(btn_out_m), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_idx", 32'(step_idx), 0);
      sys_rst = 1'b0;

      for (int r = 0; r < 4; r++) begin
         btn_live = pass_tab[r].live;
         tick();
         chk("pass_btn", 32'(btn_out), 32'(pass_tab[r].exp_ovr));
         chk("pass_btn_m", 32'(btn_out_m), 32'(pass_tab[r].exp_mrg));
         chk("pass_busy", 32'(busy), 0);
      end

      prog(0, 5'b00001, 16'd4);
      prog(1, 5'b10000, 16'd2);
      prog(2, 5'b00000, 16'd1);
      script_len = 5'd3;
      push_play(3, 5'b00000);
      start_play();
      run_sb("play");

      loop_en = 1'b1;
      push_loop(3, 20);
      start_play();
      run_sb("loop");
      stop = 1'b1; btn_live = 5'b01010;
      tick();
      stop = 1'b0;
      chk("stop_btn", 32'(btn_out), 32'(5'b01010));
      chk("stop_busy", 32'(busy), 0);
      chk("stop_done", 32'(done), 0);
      loop_en = 1'b0; btn_live = '0;
      tick();

      btn_live = 5'b00110;
      start_play();
      repeat (6) tick();
      chk("mid_idx", 32'(step_idx), 2);
      chk("mid_btn_m", 32'(btn_out_m), 32'(5'b00110));
      sys_rst = 1'b1;
      #1;
      chk("arst_btn_m", 32'(btn_out_m), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_idx", 32'(step_idx), 0);
      tick();
      chk("arst_done", 32'(done), 0);
      sys_rst = 1'b0;
      tick();
      chk("arst_done2", 32'(done), 0);
      chk("arst_busy2", 32'(busy), 0);
      btn_live = '0;
      tick();
      push_play(3, 5'b00000);
      start_play();
      run_sb("replay");

      for (int r = 0; r < 4; r++) begin
         btn_live = '0;
         prog(0, merge_tab[r].mask, 16'd3);
         script_len = 5'd1;
         btn_live = merge_tab[r].live;
         start_play();
         chk("merge_ovr", 32'(btn_out), 32'(merge_tab[r].exp_ovr));
         chk("merge_mrg", 32'(btn_out_m), 32'(merge_tab[r].exp_mrg));
         repeat (3) tick();
         chk("merge_done", 32'(done), 1);
         chk("merge_done_m", 32'(done_m), 1);
         chk("merge_idle", 32'(btn_out), 32'(merge_tab[r].live));
         tick();
      end
      btn_live = '0;

      prog(0, 5'b00001, 16'd4);
      script_len = 5'd3;
      push_play(3, 5'b00000);
      start_play();
      prog_we = 1'b1; prog_addr = 4'd1; prog_mask = 5'b11111; prog_dur = 16'd9;
      run_sb("wrbusy");
      prog_we = 1'b0;
      push_play(3, 5'b00000);
      start_play();
      run_sb("wrcheck");

      script_len = 5'd0;
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      chk("len0_busy", 32'(busy), 0);
      chk("len0_idx", 32'(step_idx), 0);
      chk("len0_done", 32'(done), 0);

      for (int i = 0; i < 16; i++) prog(i, 5'(i + 1), 16'(i % 3));
      script_len = 5'd20;
      push_play(16, 5'b00000);
      start_play();
      run_sb("len20");

      prog(0, 5'b00011, 16'd0);
      prog(1, 5'b00100, 16'hFFFF);
      script_len = 5'd2;
      push_play(2, 5'b00000);
      start_play();
      run_sb("long");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
